ifu_fetch: RTL

Instruction fetch stage of the NPC core. Directly upstream of decode, which carries the immediate generator.
- Owns the PC and issues one request at a time to instruction memory over a valid/ready request channel with a valid-only response.
- Presents {instr, pc} to decode over a valid/ready handshake.
- Accepts redirects (branch/jump target) from execute.

---
 rtl/ifu_fetch_pkg.sv | 15 +
 rtl/ifu_pc_reg.sv | 39 +++
 rtl/ifu_fetch.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, widths and PC constants.
// Imported by ifu_fetch and ifu_pc_reg.
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_HOLD = 2'd2
  } ifu_state_e;

  localparam int          INSTR_W      = 32;
  localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
  localparam int          PC_INC       = 4;

endpackage

// File: rtl/ifu_pc_reg.sv
// PC register with next-PC select (redirect > increment > hold); one-cycle update, no backpressure.
// The increment wraps modulo 2^XLEN and redirect targets are loaded verbatim.
module ifu_pc_reg
  import ifu_fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            inc_en,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect_en) begin
      pc_d = redirect_pc;
    end else if (inc_en) begin
      pc_d = pc_q + XLEN'(PC_INC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: one outstanding imem request, {instr,pc} held to decode until out_ready; 3 cycles/instr at zero wait.
// Outputs are decoded from registered state only. Define IFU_PERF_EN to add fetch/wait performance counters.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [XLEN-1:0]    out_pc,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc
`ifdef IFU_PERF_EN
  ,
  output logic [63:0]        perf_fetch_cnt,
  output logic [63:0]        perf_wait_cnt
`endif
);

  ifu_state_e         state_q, state_d;
  logic               drop_q, drop_d;
  logic [INSTR_W-1:0] out_instr_q, out_instr_d;
  logic [XLEN-1:0]    out_pc_q, out_pc_d;
  logic [XLEN-1:0]    pc;
  logic               pc_inc;

  ifu_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect_en (redirect_valid),
    .redirect_pc (redirect_pc),
    .inc_en      (pc_inc),
    .pc          (pc)
  );

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    pc_inc      = 1'b0;
    case (state_q)
      IFU_REQ: begin
        // A redirect in the accept cycle means the old address went out; its response is stale.
        if (imem_req_ready) begin
          state_d = IFU_WAIT;
          drop_d  = redirect_valid;
        end
      end
      IFU_WAIT: begin
        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          if (drop_q || redirect_valid) begin
            state_d = IFU_REQ;
          end else begin
            state_d     = IFU_HOLD;
            out_instr_d = imem_rsp_data;
            out_pc_d    = pc;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      IFU_HOLD: begin
        if (redirect_valid) begin
          state_d = IFU_REQ;
        end else if (out_ready) begin
          state_d = IFU_REQ;
          pc_inc  = 1'b1;
        end
      end
      default: begin
        state_d = IFU_REQ;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IFU_REQ;
      drop_q      <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  assign imem_req_valid = (state_q == IFU_REQ);
  assign imem_req_addr  = pc;
  assign out_valid      = (state_q == IFU_HOLD);
  assign out_instr      = out_instr_q;
  assign out_pc         = out_pc_q;

`ifdef IFU_PERF_EN
  logic [63:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
  logic [63:0] perf_wait_cnt_q, perf_wait_cnt_d;

  always_comb begin
    perf_fetch_cnt_d = perf_fetch_cnt_q + 64'(out_valid && out_ready);
    perf_wait_cnt_d  = perf_wait_cnt_q + 64'(state_q == IFU_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt_q <= '0;
      perf_wait_cnt_q  <= '0;
    end else begin
      perf_fetch_cnt_q <= perf_fetch_cnt_d;
      perf_wait_cnt_q  <= perf_wait_cnt_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_q;
  assign perf_wait_cnt  = perf_wait_cnt_q;
`endif

endmodule
